led_bar_pattern_gen: RTL and testbench

- Parametrised LED-bar pattern generator that drives a WIDTH-bit bar from a prescaled step tick.
- Four run-time selectable patterns: binary count up, binary count down, ping-pong single-LED scan, and all-on/all-off blink.
- Run/pause control, single-step input and a 4-level speed divider.
- Sits between board pushbuttons/switches and the bar LED pins; generalises the fixed 10-bit count-up blinker.

---
 rtl/led_bar_pattern_gen.sv | 135 +++++++++++++
 tb/tb_led_bar_pattern_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/led_bar_pattern_gen.sv
// led_bar_pattern_gen: WIDTH-bit LED bar pattern generator driven by a
// prescaled step tick. Patterns: count up, count down, ping-pong scan, blink.
// Run/pause, single-step and a 4-level speed divider.
// Build option: define LEDOUT_ACTIVE_LOW_EN for common-anode bars
// (LEDOUT = ~pattern, all LEDs off in reset).
module led_bar_pattern_gen #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 3000000,
    parameter int PS_W     = 25
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [1:0]       MODE,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [1:0]       SPEED,
    output logic [WIDTH-1:0] LEDOUT,
    output logic             STEP_EV
);

    typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_t;

    localparam logic [1:0]       M_UP   = 2'b00;
    localparam logic [1:0]       M_DOWN = 2'b01;
    localparam logic [1:0]       M_SCAN = 2'b10;
    localparam logic [PS_W-1:0]  PS_MAX = PS_W'(PRESCALE);
    localparam logic [PS_W-1:0]  PS_ONE = PS_W'(1);
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [WIDTH-1:0] ONES   = '1;
    localparam logic [WIDTH-1:0] BIT0   = WIDTH'(1);

    logic [PS_W-1:0]  prescaler;
    logic [2:0]       subdiv;
    logic [WIDTH-1:0] pattern;
    dir_t             scan_dir;
    logic [1:0]       mode_q;

    logic             base_tick, adv_run, adv, mode_chg, one_hot, go_left;
    logic [2:0]       sub_lim;
    logic [WIDTH-1:0] pat_init, pat_next;
    dir_t             dir_next;

    // Tick generation, speed limit, advance qualification
    always_comb begin
        case (SPEED)
            2'd0:    sub_lim = 3'd0;
            2'd1:    sub_lim = 3'd1;
            2'd2:    sub_lim = 3'd3;
            default: sub_lim = 3'd7;
        endcase
        base_tick = RUN && (prescaler == PS_MAX);
        adv_run   = base_tick && (subdiv == sub_lim);
        adv       = (RUN && adv_run) || (!RUN && STEP);
        mode_chg  = (MODE != mode_q);
    end

    // Next pattern for the current mode, and reload value for a new mode
    always_comb begin
        pat_init = ZERO;
        case (MODE)
            M_DOWN:  pat_init = ONES;
            M_SCAN:  pat_init = BIT0;
            default: pat_init = ZERO;
        endcase

        one_hot  = (pattern != ZERO) && ((pattern & (pattern - BIT0)) == ZERO);
        // Head left unless already at the top; bit0 always bounces left
        go_left  = ((scan_dir == LEFT) && !pattern[WIDTH-1]) || pattern[0];
        pat_next = pattern;
        dir_next = scan_dir;
        case (mode_q)
            M_UP:   pat_next = pattern + BIT0;
            M_DOWN: pat_next = pattern - BIT0;
            M_SCAN: begin
                if (!one_hot) begin
                    pat_next = BIT0;
                    dir_next = LEFT;
                end else if (go_left) begin
                    pat_next = pattern << 1;
                    dir_next = pattern[WIDTH-2] ? RIGHT : LEFT;
                end else begin
                    pat_next = pattern >> 1;
                    dir_next = pattern[1] ? LEFT : RIGHT;
                end
            end
            default: pat_next = (pattern == ZERO) ? ONES : ZERO;
        endcase
    end

    // Prescaler, speed divider, scan FSM and pattern register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            prescaler <= '0;
            subdiv    <= '0;
            pattern   <= ZERO;
            scan_dir  <= LEFT;
            mode_q    <= M_UP;
            STEP_EV   <= 1'b0;
        end else begin
            mode_q  <= MODE;
            STEP_EV <= 1'b0;
            if (mode_chg) begin
                // New mode restarts from its seed; a coincident advance is dropped
                pattern   <= pat_init;
                scan_dir  <= LEFT;
                prescaler <= '0;
                subdiv    <= '0;
            end else begin
                if (!RUN || base_tick)
                    prescaler <= '0;
                else
                    prescaler <= prescaler + PS_ONE;

                // Reaching or overshooting the limit clears; only an exact hit advances
                if (!RUN)
                    subdiv <= '0;
                else if (base_tick)
                    subdiv <= (subdiv >= sub_lim) ? 3'd0 : subdiv + 3'd1;

                if (adv) begin
                    pattern  <= pat_next;
                    scan_dir <= dir_next;
                    STEP_EV  <= 1'b1;
                end
            end
        end
    end

`ifdef LEDOUT_ACTIVE_LOW_EN
    assign LEDOUT = ~pattern;
`else
    assign LEDOUT = pattern;
`endif

endmodule

// File: tb/tb_led_bar_pattern_gen.sv
// Bench for led_bar_pattern_gen at WIDTH=4, PRESCALE=3: table of
// {mode, speed, cycles-to-wait, expected STEP_EV, expected pattern}
// plus hand sequences for pause/step, resume timing and async reset.
module tb_led_bar_pattern_gen;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [1:0] MODE;
    logic       RUN;
    logic       STEP;
    logic [1:0] SPEED;
    logic [3:0] LEDOUT;
    logic       STEP_EV;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        logic [1:0] speed;
        int         gap;
        logic       ev;
        logic [3:0] led;
    } vec_t;

    vec_t tbl[$];

    led_bar_pattern_gen #(.WIDTH(4), .PRESCALE(3), .PS_W(3)) dut (
        .CLK(CLK), .RSTn(RSTn), .MODE(MODE), .RUN(RUN), .STEP(STEP),
        .SPEED(SPEED), .LEDOUT(LEDOUT), .STEP_EV(STEP_EV)
    );

    always #5 CLK = ~CLK;

    // Expected pin value for a given pattern
    function automatic logic [3:0] lm(input logic [3:0] p);
`ifdef LEDOUT_ACTIVE_LOW_EN
        return ~p;
`else
        return p;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic [1:0] s,
                                input int g, input logic e, input logic [3:0] l);
        vec_t v;
        v.mode = m; v.speed = s; v.gap = g; v.ev = e; v.led = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Run 'gap' cycles; no event allowed before the last, then check it
    task automatic wait_ev(input int gap, input logic exp_ev, input logic [3:0] exp_led,
                           input string nm);
        int early = 0;
        for (int c = 1; c <= gap; c++) begin
            @(posedge CLK); #1;
            if (c < gap && STEP_EV === 1'b1) early++;
        end
        chk({nm, "_early"}, early, 0);
        chk({nm, "_ev"}, {31'd0, STEP_EV}, {31'd0, exp_ev});
        chk({nm, "_led"}, {28'd0, LEDOUT}, {28'd0, lm(exp_led)});
    endtask

    initial begin
        // count up: 1..15 then wrap to 0
        for (int k = 1; k <= 16; k++) tbl.push_back(mk(2'b00, 2'd0, 4, 1'b1, 4'(k)));
        // scan: reload bit0 on entry, bounce at both ends
        tbl.push_back(mk(2'b10, 2'd0, 1, 1'b0, 4'b0001));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b0010));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b0100));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b1000));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b0100));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b0010));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b0001));
        tbl.push_back(mk(2'b10, 2'd0, 4, 1'b1, 4'b0010));
        // blink at SPEED=2 then SPEED=0
        tbl.push_back(mk(2'b11, 2'd2, 1, 1'b0, 4'b0000));
        tbl.push_back(mk(2'b11, 2'd2, 16, 1'b1, 4'b1111));
        tbl.push_back(mk(2'b11, 2'd2, 16, 1'b1, 4'b0000));
        tbl.push_back(mk(2'b11, 2'd0, 4, 1'b1, 4'b1111));
        tbl.push_back(mk(2'b11, 2'd0, 4, 1'b1, 4'b0000));
        // subdiv above new limit: one silent tick before advancing
        tbl.push_back(mk(2'b11, 2'd1, 8, 1'b1, 4'b1111));
        tbl.push_back(mk(2'b11, 2'd1, 4, 1'b0, 4'b1111));
        tbl.push_back(mk(2'b11, 2'd0, 8, 1'b1, 4'b0000));
        // mode switch 00->01 landing on an advance cycle
        tbl.push_back(mk(2'b00, 2'd0, 1, 1'b0, 4'b0000));
        tbl.push_back(mk(2'b00, 2'd0, 3, 1'b0, 4'b0000));
        tbl.push_back(mk(2'b01, 2'd0, 1, 1'b0, 4'b1111));
        tbl.push_back(mk(2'b01, 2'd0, 4, 1'b1, 4'b1110));

        RSTn = 1'b0; MODE = 2'b00; RUN = 1'b1; STEP = 1'b0; SPEED = 2'd0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_led", {28'd0, LEDOUT}, {28'd0, lm(4'b0000)});
        chk("reset_ev", {31'd0, STEP_EV}, 32'd0);
        RSTn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            MODE  = tbl[i].mode;
            SPEED = tbl[i].speed;
            wait_ev(tbl[i].gap, tbl[i].ev, tbl[i].led, $sformatf("vec%0d", i));
        end

        // Paused single-step in count-down from reset
        RSTn = 1'b0; MODE = 2'b01; RUN = 1'b0; SPEED = 2'd0;
        @(posedge CLK); #1;
        chk("step_reset_led", {28'd0, LEDOUT}, {28'd0, lm(4'b0000)});
        RSTn = 1'b1;
        wait_ev(1, 1'b0, 4'b1111, "step_load");
        wait_ev(6, 1'b0, 4'b1111, "paused_idle");
        for (int p = 0; p < 3; p++) begin
            STEP = 1'b1;
            @(posedge CLK); #1;
            STEP = 1'b0;
            chk($sformatf("step%0d_ev", p), {31'd0, STEP_EV}, 32'd1);
            chk($sformatf("step%0d_led", p), {28'd0, LEDOUT}, {28'd0, lm(4'(14 - p))});
            @(posedge CLK); #1;
            chk($sformatf("step%0d_single", p), {31'd0, STEP_EV}, 32'd0);
        end
        // STEP ignored while running; first tick PRESCALE+1 cycles after RUN rises
        RUN = 1'b1; STEP = 1'b1;
        @(posedge CLK); #1;
        STEP = 1'b0;
        chk("run_step_ignored", {31'd0, STEP_EV}, 32'd0);
        wait_ev(3, 1'b1, 4'b1011, "resume");

        // Async reset mid-scan
        MODE = 2'b10;
        wait_ev(1, 1'b0, 4'b0001, "scan2_load");
        wait_ev(4, 1'b1, 4'b0010, "scan2_a");
        wait_ev(4, 1'b1, 4'b0100, "scan2_b");
        #3 RSTn = 1'b0;
        #1;
        chk("async_rst_led", {28'd0, LEDOUT}, {28'd0, lm(4'b0000)});
        chk("async_rst_ev", {31'd0, STEP_EV}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        wait_ev(1, 1'b0, 4'b0001, "scan3_load");
        wait_ev(4, 1'b1, 4'b0010, "scan3_a");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
